// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - Shared encodings for the SR latch sequencer
package sr_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PULSE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic OP_SET = 1'b0;
  localparam logic OP_CLR = 1'b1;

  // A request is redundant when the latch already holds the value it asks for.
  function automatic logic is_redundant(input logic op, input logic q);
    return (op == OP_SET) ? q : !q;
  endfunction

endpackage

// File: rtl/sr_gate.sv
// rtl/sr_gate.sv - Cross-coupled NAND SR latch with active-low set/reset inputs
module sr_gate (
  input  logic sb,
  input  logic rb,
  output logic q,
  output logic qbar
);

  logic r_q;

  // Set dominates only as a tie-break; the sequencer never presents sb=rb=0.
  always_latch begin
    if (!sb) begin
      r_q <= 1'b1;
    end else if (!rb) begin
      r_q <= 1'b0;
    end
  end

  assign q    = r_q;
  assign qbar = !r_q;

endmodule

// File: rtl/sr_latch_sequencer.sv
// rtl/sr_latch_sequencer.sv - Pulse/settle strobe sequencer arbitrating set and clear requests into a NAND latch
module sr_latch_sequencer
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic ack_set,
  output logic ack_clr,
  output logic busy,
  output logic sb,
  output logic rb,
  output logic q,
  output logic qbar
);

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_op, w_op_nxt;
  logic             r_prio_clr, w_prio_clr_nxt;
  logic             r_set_low, w_set_low_nxt;
  logic             r_clr_low, w_clr_low_nxt;
  logic             r_ack_set, w_ack_set_nxt;
  logic             r_ack_clr, w_ack_clr_nxt;
  logic             w_grant, w_grant_op;

  always_comb begin
    w_grant    = set_req | clr_req;
    w_grant_op = OP_SET;
    if (set_req && clr_req) begin
      w_grant_op = r_prio_clr ? OP_CLR : OP_SET;
    end else if (clr_req) begin
      w_grant_op = OP_CLR;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_op_nxt       = r_op;
    w_prio_clr_nxt = r_prio_clr;
    w_ack_set_nxt  = 1'b0;
    w_ack_clr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_prio_clr_nxt = !r_prio_clr;
          if (is_redundant(w_grant_op, q)) begin
            w_ack_set_nxt = (w_grant_op == OP_SET);
            w_ack_clr_nxt = (w_grant_op == OP_CLR);
          end else begin
            w_state_nxt = S_PULSE;
            w_op_nxt    = w_grant_op;
            w_cnt_nxt   = PULSE_LD;
          end
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Ack is registered so it lands in the final SETTLE cycle.
    if (w_state_nxt == S_SETTLE && w_cnt_nxt == '0) begin
      w_ack_set_nxt = (w_op_nxt == OP_SET);
      w_ack_clr_nxt = (w_op_nxt == OP_CLR);
    end

    w_set_low_nxt = (w_state_nxt == S_PULSE) && (w_op_nxt == OP_SET);
    w_clr_low_nxt = (w_state_nxt == S_PULSE) && (w_op_nxt == OP_CLR);
  end

  // Strobes are held as active-low flags so an unreset flop reads as sb=rb=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_CLR;
      r_prio_clr <= 1'b1;
      r_set_low  <= 1'b0;
      r_clr_low  <= 1'b1;
      r_ack_set  <= 1'b0;
      r_ack_clr  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op       <= w_op_nxt;
      r_prio_clr <= w_prio_clr_nxt;
      r_set_low  <= w_set_low_nxt;
      r_clr_low  <= w_clr_low_nxt;
      r_ack_set  <= w_ack_set_nxt;
      r_ack_clr  <= w_ack_clr_nxt;
    end
  end

  assign sb      = !r_set_low;
  assign rb      = !r_clr_low;
  assign busy    = (r_state != S_IDLE);
  assign ack_set = r_ack_set;
  assign ack_clr = r_ack_clr;

  sr_gate u_sr_gate (
    .sb   (sb),
    .rb   (rb),
    .q    (q),
    .qbar (qbar)
  );

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// tb/tb_sr_latch_sequencer.sv - Directed vector and randomized safety bench for sr_latch_sequencer
module tb_sr_latch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic set_req = 1'b0, clr_req = 1'b0;
  logic ack_set, ack_clr, busy, sb, rb, q, qbar;

  logic b_set = 1'b0, b_clr = 1'b0;
  logic b_ack_set, b_ack_clr, b_busy, b_sb, b_rb, b_q, b_qbar;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic sb;
    logic rb;
    logic q;
    logic busy;
    logic ack_set;
    logic ack_clr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sr_latch_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .ack_set (ack_set),
    .ack_clr (ack_clr),
    .busy    (busy),
    .sb      (sb),
    .rb      (rb),
    .q       (q),
    .qbar    (qbar)
  );

  sr_latch_sequencer #(.PULSE_W(1), .SETTLE_W(3)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (b_set),
    .clr_req (b_clr),
    .ack_set (b_ack_set),
    .ack_clr (b_ack_clr),
    .busy    (b_busy),
    .sb      (b_sb),
    .rb      (b_rb),
    .q       (b_q),
    .qbar    (b_qbar)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic c, input logic e_sb,
                     input logic e_rb, input logic e_q, input logic e_busy,
                     input logic e_as, input logic e_ac);
    vec_t v;
    v.rst_n = r; v.set_req = s; v.clr_req = c;
    v.sb = e_sb; v.rb = e_rb; v.q = e_q; v.busy = e_busy;
    v.ack_set = e_as; v.ack_clr = e_ac;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ack_at, busy_cnt, sb_low_cnt;
    logic p_as, p_ac, p2_as, p2_ac;

    //  rst set clr | sb rb q busy ack_s ack_c
    add(0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(1, 0, 0,   1, 1, 0, 0, 0, 0);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   1, 1, 1, 1, 1, 0);
    add(1, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(1, 1, 1,   1, 1, 0, 0, 0, 1);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   1, 1, 1, 1, 1, 0);
    add(1, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 1, 1,   1, 0, 0, 1, 0, 0);
    add(1, 1, 1,   1, 0, 0, 1, 0, 0);
    add(1, 1, 1,   1, 1, 0, 1, 0, 1);
    add(1, 1, 0,   1, 1, 0, 0, 0, 0);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   0, 1, 1, 1, 0, 0);
    add(1, 1, 0,   1, 1, 1, 1, 1, 0);
    add(1, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 1, 0,   1, 1, 1, 0, 1, 0);
    add(1, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 0, 1,   1, 0, 0, 1, 0, 0);
    add(1, 0, 0,   1, 0, 0, 1, 0, 0);
    add(1, 0, 0,   1, 1, 0, 1, 0, 1);
    add(1, 0, 0,   1, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      rst_n   = vecs[i].rst_n;
      set_req = vecs[i].set_req;
      clr_req = vecs[i].clr_req;
      @(negedge clk);
      chk($sformatf("v%0d.sb", i),      sb,      vecs[i].sb);
      chk($sformatf("v%0d.rb", i),      rb,      vecs[i].rb);
      chk($sformatf("v%0d.q", i),       q,       vecs[i].q);
      chk($sformatf("v%0d.qbar", i),    qbar,    !vecs[i].q);
      chk($sformatf("v%0d.busy", i),    busy,    vecs[i].busy);
      chk($sformatf("v%0d.ack_set", i), ack_set, vecs[i].ack_set);
      chk($sformatf("v%0d.ack_clr", i), ack_clr, vecs[i].ack_clr);
    end

    // Reset dropped in the second PULSE cycle of a set.
    set_req = 1'b1;
    @(negedge clk);
    chk("midrst.pulse1_sb", sb, 1'b0);
    @(posedge clk);
    #2;
    chk("midrst.pulse2_sb", sb, 1'b0);
    rst_n   = 1'b0;
    set_req = 1'b0;
    #1;
    chk("midrst.sb", sb, 1'b1);
    chk("midrst.rb", rb, 1'b0);
    chk("midrst.q", q, 1'b0);
    chk("midrst.qbar", qbar, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst.no_ack%0d", k), ack_set, 1'b0);
      chk($sformatf("midrst.busy%0d", k), busy, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.rel_ack", ack_set, 1'b0);
    chk("midrst.rel_rb", rb, 1'b1);
    chk("midrst.rel_q", q, 1'b0);

    // PULSE_W=1, SETTLE_W=3 instance.
    ack_at = 0; busy_cnt = 0; sb_low_cnt = 0;
    b_set = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (b_busy) busy_cnt++;
      if (!b_sb) sb_low_cnt++;
      if (b_ack_set) begin
        if (ack_at == 0) ack_at = k;
        b_set = 1'b0;
      end
    end
    b_set = 1'b0;
    chk_int("p1s3.ack_cycle", ack_at, 4);
    chk_int("p1s3.busy_cycles", busy_cnt, 4);
    chk_int("p1s3.sb_low_cycles", sb_low_cnt, 1);
    chk("p1s3.q", b_q, 1'b1);
    chk("p1s3.busy_end", b_busy, 1'b0);

    // Random requesters that hold each request until its ack.
    p_as = 0; p_ac = 0; p2_as = 0; p2_ac = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk("rand.sb_or_rb", sb | rb, 1'b1);
      chk("rand.b_sb_or_rb", b_sb | b_rb, 1'b1);
      chk("rand.ack_set_width", ack_set & p_as, 1'b0);
      chk("rand.ack_clr_width", ack_clr & p_ac, 1'b0);
      chk("rand.b_ack_set_width", b_ack_set & p2_as, 1'b0);
      chk("rand.b_ack_clr_width", b_ack_clr & p2_ac, 1'b0);
      p_as = ack_set; p_ac = ack_clr; p2_as = b_ack_set; p2_ac = b_ack_clr;
      if (ack_set) set_req = 1'b0;
      else if (!set_req && $urandom_range(3, 0) == 0) set_req = 1'b1;
      if (ack_clr) clr_req = 1'b0;
      else if (!clr_req && $urandom_range(3, 0) == 0) clr_req = 1'b1;
      if (b_ack_set) b_set = 1'b0;
      else if (!b_set && $urandom_range(3, 0) == 0) b_set = 1'b1;
      if (b_ack_clr) b_clr = 1'b0;
      else if (!b_clr && $urandom_range(3, 0) == 0) b_clr = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_sequencer.md
SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W, default 2, the number of cycles an active-low strobe is held low (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_W, default 1, the number of cycles both strobes stay high after a pulse, before ack (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port set_req, input, 1 bit: requester A asks for Q=1; level, held until ack.
REQ-006 SHALL have port clr_req, input, 1 bit: requester B asks for Q=0; level, held until ack.
REQ-007 SHALL have port ack_set, output, 1 bit: one-cycle pulse marking completion of a set request.
REQ-008 SHALL have port ack_clr, output, 1 bit: one-cycle pulse marking completion of a clear request.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port sb, output, 1 bit: registered active-low set strobe driven into the latch.
REQ-011 SHALL have port rb, output, 1 bit: registered active-low reset strobe driven into the latch.
REQ-012 SHALL have ports q and qbar, output, 1 bit each: the latch outputs.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, PULSE, SETTLE.
REQ-014 In IDLE, SHALL sample the requests each cycle; on a request it SHALL latch the operation (SET or CLR) and go to PULSE on the next edge.
REQ-015 In PULSE, SHALL drive only the selected strobe low for exactly PULSE_W cycles, then go to SETTLE.
REQ-016 In SETTLE, SHALL hold sb=rb=1 for SETTLE_W cycles, pulse the matching ack in the final SETTLE cycle, then return to IDLE.
REQ-017 Latency: with a request sampled at edge N, the strobe SHALL be low for cycles N+1..N+PULSE_W, and ack SHALL be high in cycle N+PULSE_W+SETTLE_W.
REQ-018 SHALL never drive sb=0 and rb=0 in the same cycle, in any state or during reset (forbidden NAND-latch input).
REQ-019 With set_req and clr_req both high in IDLE, SHALL grant by a round-robin priority bit that toggles after every grant; the bit's reset value favours clr.
REQ-020 The losing request SHALL be served, if still high, in the first IDLE cycle after the winner's ack.
REQ-021 Requests arriving while busy SHALL be ignored; they are not queued except by level-hold.
REQ-022 A redundant request (set_req with q=1, or clr_req with q=0) SHALL skip PULSE and SETTLE, and the matching ack SHALL pulse in the cycle after sampling; busy SHALL stay low.
REQ-023 A request deasserted before ack SHALL NOT abort the sequence; the ack SHALL still be issued.
REQ-024 The cycle counter SHALL be 4 bits, count down, and reload on every state entry.

Reset
REQ-025 While rst_n=0, SHALL force state=IDLE, sb=1, rb=0 (latch cleared), ack_set=ack_clr=0, busy=0, and priority=clr.
REQ-026 After reset release, rb SHALL return to 1 on the first clock edge; q=0 and qbar=1 SHALL hold.
REQ-027 Reset asserted mid-PULSE SHALL immediately raise sb (if low) and lower rb with no 00 overlap, and SHALL issue no ack.

Structure
REQ-028 Package sr_ctrl_pkg SHALL hold the state encoding (IDLE=2'd0, PULSE=2'd1, SETTLE=2'd2), the op encoding (OP_SET, OP_CLR), and the counter width constant CNT_W=4.
REQ-029 SHALL instantiate one sub-module, sr_gate (cross-coupled NAND latch: Sb, Rb, Q, Qbar), driven by the registered sb and rb.

Verification
REQ-030 Reset then set_req=1 held: at PULSE_W=2, SETTLE_W=1, sb is low for 2 cycles, ack_set is high 3 cycles after sampling, and q=1, qbar=0.
REQ-031 set_req and clr_req rise together after reset: CLR is granted first (redundant, ack_clr the next cycle), then SET is performed, then priority favours clr again.
REQ-032 clr_req is pulsed 1 cycle while q=1: the full sequence completes, ack_clr fires once, and q=0.
REQ-033 rst_n dropped in the 2nd PULSE cycle of a set: sb=1, rb=0 immediately, q=0, and no ack_set appears.
REQ-034 Random requests over 10,000 cycles: an assertion confirms sb|rb is always 1 and each ack is exactly one cycle wide.
REQ-035 PULSE_W=1, SETTLE_W=3: strobe is low 1 cycle, ack arrives 4 cycles after sampling, and busy is high for 4 cycles.
